// File: rtl/pwm_array_pkg.sv
// Shared definitions for the multi-channel PWM engine: channel FSM encoding,
// default sizing and the channel-index width helper.
package pwm_array_pkg;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } pwm_state_e;

  // Channel-index width; a single channel still needs one select bit.
  function automatic int f_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_array_if.sv
// Configuration write bus from the CSR decoder into the PWM array.
interface pwm_array_if
  import pwm_array_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);
  localparam int CH_W = f_ch_w(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_low;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_pol;

  modport master (
    output cfg_valid, cfg_ch, cfg_high, cfg_low, cfg_phase, cfg_pol,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_high, cfg_low, cfg_phase, cfg_pol,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_array_channel.sv
// One PWM channel: shadow/active configuration, phase/high/low down-counter
// FSM and registered output / period pulse. New settings take effect only at
// start, sync or the end of a LOW phase, so the pin never sees a runt pulse.
module pwm_array_channel
  import pwm_array_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_high,
  input  logic [CNT_W-1:0] i_low,
  input  logic [CNT_W-1:0] i_phase,
  input  logic             i_pol,
  output logic             o_out,
  output logic             o_done,
  output logic             o_pending
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pwm_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_sh_high, r_sh_low, r_sh_phase;
  logic [CNT_W-1:0] r_act_high, r_act_low;
  logic             r_sh_pol, r_act_pol, r_pending, r_out, r_done;

  pwm_state_e       w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt, w_nxt_high, w_nxt_low;
  logic             w_commit, w_nxt_pol, w_nxt_out, w_nxt_done;

  // First state of a period: HIGH if it has any length, otherwise LOW
  // (LOW also parks the degenerate high=low=0 configuration).
  function automatic pwm_state_e f_ent_state(input logic [CNT_W-1:0] hi);
    pwm_state_e st;
    if (hi != '0) st = ST_HIGH;
    else          st = ST_LOW;
    return st;
  endfunction

  function automatic logic [CNT_W-1:0] f_ent_cnt(input logic [CNT_W-1:0] hi,
                                                 input logic [CNT_W-1:0] lo);
    logic [CNT_W-1:0] c;
    if (hi != '0)      c = hi - ONE;
    else if (lo != '0) c = lo - ONE;
    else               c = '0;
    return c;
  endfunction

  // Next state / counter and whether this edge commits shadow into active.
  always_comb begin
    w_commit    = 1'b0;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    if (!i_run) begin
      w_nxt_state = ST_IDLE;
      w_nxt_cnt   = '0;
    end else if ((r_state == ST_IDLE) || i_sync) begin
      w_commit = 1'b1;
      if (r_sh_phase != '0) begin
        w_nxt_state = ST_PHASE;
        w_nxt_cnt   = r_sh_phase - ONE;
      end else begin
        w_nxt_state = f_ent_state(r_sh_high);
        w_nxt_cnt   = f_ent_cnt(r_sh_high, r_sh_low);
      end
    end else begin
      case (r_state)
        ST_PHASE: begin
          if (r_cnt != '0) begin
            w_nxt_cnt = r_cnt - ONE;
          end else begin
            w_nxt_state = f_ent_state(r_act_high);
            w_nxt_cnt   = f_ent_cnt(r_act_high, r_act_low);
          end
        end
        ST_HIGH: begin
          if (r_cnt != '0) begin
            w_nxt_cnt = r_cnt - ONE;
          end else if (r_act_low != '0) begin
            w_nxt_state = ST_LOW;
            w_nxt_cnt   = r_act_low - ONE;
          end else begin
            w_commit    = 1'b1;
            w_nxt_state = f_ent_state(r_sh_high);
            w_nxt_cnt   = f_ent_cnt(r_sh_high, r_sh_low);
          end
        end
        ST_LOW: begin
          if (r_cnt != '0) begin
            w_nxt_cnt = r_cnt - ONE;
          end else begin
            w_commit    = 1'b1;
            w_nxt_state = f_ent_state(r_sh_high);
            w_nxt_cnt   = f_ent_cnt(r_sh_high, r_sh_low);
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Config in force after this edge; period_done is looked ahead so the
  // registered pulse lines up with the final cycle of the period.
  assign w_nxt_high = w_commit ? r_sh_high : r_act_high;
  assign w_nxt_low  = w_commit ? r_sh_low  : r_act_low;
  assign w_nxt_pol  = w_commit ? r_sh_pol  : r_act_pol;
  assign w_nxt_out  = (w_nxt_state == ST_HIGH) ^ w_nxt_pol;
  assign w_nxt_done = (w_nxt_cnt == '0) && ((w_nxt_high != '0) || (w_nxt_low != '0)) &&
                      ((w_nxt_state == ST_LOW) || ((w_nxt_state == ST_HIGH) && (w_nxt_low == '0)));

  // Channel state, counter, shadow/active config and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sh_high  <= '0;
      r_sh_low   <= '0;
      r_sh_phase <= '0;
      r_sh_pol   <= 1'b0;
      r_act_high <= '0;
      r_act_low  <= '0;
      r_act_pol  <= 1'b0;
      r_pending  <= 1'b0;
      r_out      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_out   <= w_nxt_out;
      r_done  <= w_nxt_done;
      if (w_commit) begin
        r_act_high <= r_sh_high;
        r_act_low  <= r_sh_low;
        r_act_pol  <= r_sh_pol;
      end
      // A write is only accepted while nothing is pending, so a same-edge
      // commit still takes the old shadow and the new data stays pending.
      if (i_wr) begin
        r_sh_high  <= i_high;
        r_sh_low   <= i_low;
        r_sh_phase <= i_phase;
        r_sh_pol   <= i_pol;
        r_pending  <= 1'b1;
      end else if (w_commit) begin
        r_pending  <= 1'b0;
      end
    end
  end

  assign o_out     = r_out;
  assign o_done    = r_done;
  assign o_pending = r_pending;

endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM array: config write decode with per-channel backpressure
// and NUM_CH independent channels sharing the global enable and sync.
module pwm_array
  import pwm_array_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_enable,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              pwm_sync,
  pwm_array_if.slave        cfg,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] period_done,
  output logic [NUM_CH-1:0] cfg_pending
);
  localparam int CH_W = f_ch_w(NUM_CH);

  logic              w_ready;
  logic [NUM_CH-1:0] w_wr, w_out, w_done, w_pend;

  // Ready follows the addressed channel's pending flag; out-of-range indices
  // are always ready and the write simply lands nowhere.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ready = (cfg.cfg_ch == CH_W'(i)) ? ~w_pend[i] : w_ready;
    end
  end

  assign cfg.cfg_ready = w_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg.cfg_valid & w_ready & (cfg.cfg_ch == CH_W'(g));

    pwm_array_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_run     (pwm_enable & ch_enable[g]),
      .i_sync    (pwm_sync),
      .i_wr      (w_wr[g]),
      .i_high    (cfg.cfg_high),
      .i_low     (cfg.cfg_low),
      .i_phase   (cfg.cfg_phase),
      .i_pol     (cfg.cfg_pol),
      .o_out     (w_out[g]),
      .o_done    (w_done[g]),
      .o_pending (w_pend[g])
    );
  end

  assign pwm_out     = w_out;
  assign period_done = w_done;
  assign cfg_pending = w_pend;

endmodule
